// File: rtl/shift_pipe_pkg.sv
// Shared definitions for the pipelined shifter: default sizes and op encodings.
package shift_pipe_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_RLL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10,
    OP_SRL = 2'b11
  } op_e;

endpackage

// File: rtl/shift_pipe_level.sv
// One combinational shift level of fixed amount SHAMT; passes D through when En is low.
module shift_level
  import shift_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SHAMT = 1
) (
  input  logic [WIDTH-1:0] D,
  input  logic             En,
  input  logic [1:0]       Op,
  output logic [WIDTH-1:0] Q
);

  // Select the Op-specific shift by SHAMT, or pass through.
  always_comb begin
    Q = D;
    if (En) begin
      case (op_e'(Op))
        OP_RLL:  Q = {D[WIDTH-1-SHAMT:0], D[WIDTH-1:WIDTH-SHAMT]};
        OP_SLL:  Q = {D[WIDTH-1-SHAMT:0], {SHAMT{1'b0}}};
        OP_SRA:  Q = {{SHAMT{D[WIDTH-1]}}, D[WIDTH-1:SHAMT]};
        default: Q = {{SHAMT{1'b0}}, D[WIDTH-1:SHAMT]};
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Four-stage pipelined shifter/rotator with valid/ready on both sides.
// Stage k applies a shift of 2**k (k = 0..CNT_W-1) when Cnt[k] is set.
module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  input  logic [1:0]       Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out
);

  // Stage registers
  logic [WIDTH-1:0] d_q [CNT_W];
  logic [CNT_W-1:0] c_q [CNT_W];
  logic [1:0]       o_q [CNT_W];
  logic [CNT_W-1:0] v_q;

  // Stage inputs (stage 0 is fed from the ports) and shifted results
  logic [WIDTH-1:0] src_d [CNT_W];
  logic [CNT_W-1:0] src_c [CNT_W];
  logic [1:0]       src_o [CNT_W];
  logic [CNT_W-1:0] src_v;
  logic [WIDTH-1:0] lvl_q [CNT_W];
  logic [CNT_W-1:0] adv;

  // Route each stage's source: ports for the first, previous register otherwise.
  always_comb begin
    for (int unsigned k = 0; k < CNT_W; k++) begin
      if (k == 0) begin
        src_d[k] = In;
        src_c[k] = Cnt;
        src_o[k] = Op;
        src_v[k] = in_valid;
      end else begin
        src_d[k] = d_q[k-1];
        src_c[k] = c_q[k-1];
        src_o[k] = o_q[k-1];
        src_v[k] = v_q[k-1];
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < CNT_W; g++) begin : g_level
      shift_level #(
        .WIDTH (WIDTH),
        .SHAMT (1 << g)
      ) u_level (
        .D  (src_d[g]),
        .En (src_c[g][g]),
        .Op (src_o[g]),
        .Q  (lvl_q[g])
      );
    end
  endgenerate

  // Advance chain from the output back to the input; a stage moves if it is empty or its successor moves.
  always_comb begin
    adv = '0;
    adv[CNT_W-1] = out_ready | ~v_q[CNT_W-1];
    for (int unsigned i = 0; i < CNT_W - 1; i++) begin
      adv[CNT_W-2-i] = adv[CNT_W-1-i] | ~v_q[CNT_W-2-i];
    end
  end

  // Load stages that advance; payload is only captured alongside a valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int unsigned k = 0; k < CNT_W; k++) begin
        d_q[k] <= '0;
        c_q[k] <= '0;
        o_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < CNT_W; k++) begin
        if (adv[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            d_q[k] <= lvl_q[k];
            c_q[k] <= src_c[k];
            o_q[k] <= src_o[k];
          end
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[CNT_W-1];
  assign Out       = d_q[CNT_W-1];

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed cases plus randomized traffic
// against a queue-based arithmetic reference model.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] In = '0;
  logic [3:0]  Cnt = '0;
  logic [1:0]  Op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Out;

  shift_pipe #(.WIDTH(16), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .In        (In),
    .Cnt       (Cnt),
    .Op        (Op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] exp;
    int          acc;
  } item_t;

  item_t       q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_in = 0;
  int          n_out = 0;
  logic        lat_chk = 1'b0;
  logic        last_acc, last_ir, last_ov;
  logic [15:0] last_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_shift(input logic [15:0] din, input int c, input logic [1:0] op);
    logic [31:0] x;
    logic [31:0] r;
    logic signed [31:0] s;
    x = {16'h0, din};
    s = {{16{din[15]}}, din};
    case (op)
      2'd0:    r = (x << c) | (x >> (16 - c));
      2'd1:    r = x << c;
      2'd2:    r = s >>> c;
      default: r = x >> c;
    endcase
    return r[15:0];
  endfunction

  // One cycle: drive at negedge, sample 1 unit later, score handshakes that the next posedge completes.
  task automatic step(input logic iv, input logic [15:0] din, input logic [3:0] cnt,
                      input logic [1:0] op, input logic ordy, input logic [15:0] exp);
    item_t it;
    @(negedge clk);
    in_valid  = iv;
    In        = iv ? din : 'x;
    Cnt       = iv ? cnt : 'x;
    Op        = iv ? op  : 'x;
    out_ready = ordy;
    #1;
    cyc++;
    last_acc = in_valid && in_ready;
    last_ir  = in_ready;
    last_ov  = out_valid;
    last_out = Out;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        it = q.pop_front();
        check("result", Out, it.exp);
        if (lat_chk) check("latency", cyc - it.acc, 4);
        n_out++;
      end
    end
    if (last_acc) begin
      it.exp = exp;
      it.acc = cyc;
      q.push_back(it);
      n_in++;
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, '0, ordy, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) idle(1'b1);
    check("drain_empty", q.size(), 0);
    idle(1'b1);
    check("drain_ov0", last_ov, 1'b0);
  endtask

  logic [15:0] bp_in  [6];
  logic [3:0]  bp_cnt [6];
  logic [1:0]  bp_op  [6];
  logic [15:0] held;
  logic        have_held;
  int          idx, outs, gap, start_in, start_out, sent, guard;
  logic [15:0] r_in;
  logic [3:0]  r_cnt;
  logic [1:0]  r_op;
  logic        r_iv;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out", Out, 16'h0000);
    check("rst_out_valid2", out_valid, 1'b0);

    // Test 1: directed, back-to-back, latency 4
    lat_chk = 1'b1;
    step(1'b1, 16'h1234, 4'd4,  2'b00, 1'b1, 16'h2341);
    step(1'b1, 16'h00FF, 4'd8,  2'b01, 1'b1, 16'hFF00);
    step(1'b1, 16'h8000, 4'd15, 2'b10, 1'b1, 16'hFFFF);
    step(1'b1, 16'h8000, 4'd15, 2'b11, 1'b1, 16'h0001);
    drain();
    check("t1_count", n_out, 4);
    lat_chk = 1'b0;

    // Test 2: Cnt = 0 passes through for every Op; SRA of a positive value
    for (int o = 0; o < 4; o++) step(1'b1, 16'hABCD, 4'd0, 2'(o), 1'b1, 16'hABCD);
    step(1'b1, 16'h7FFF, 4'd3, 2'b10, 1'b1, 16'h0FFF);
    drain();

    // Test 3: backpressure, 6 requests offered while out_ready is low
    for (int i = 0; i < 6; i++) begin
      bp_in[i]  = 16'h1111 * 16'(i + 1) ^ 16'h8421;
      bp_cnt[i] = 4'(3 * i + 1);
      bp_op[i]  = 2'(i);
    end
    idx = 0;
    have_held = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, bp_in[idx], bp_cnt[idx], bp_op[idx], 1'b0,
           ref_shift(bp_in[idx], int'(bp_cnt[idx]), bp_op[idx]));
      if (last_acc) idx++;
      if (last_ov) begin
        if (!have_held) begin
          held = last_out;
          have_held = 1'b1;
        end else begin
          check("bp_hold", last_out, held);
        end
      end
    end
    check("bp_accepted", idx, 4);
    check("bp_in_ready", last_ir, 1'b0);
    check("bp_out_valid", last_ov, 1'b1);
    outs = 0;
    gap = 0;
    for (int i = 0; i < 12; i++) begin
      if (idx < 6)
        step(1'b1, bp_in[idx], bp_cnt[idx], bp_op[idx], 1'b1,
             ref_shift(bp_in[idx], int'(bp_cnt[idx]), bp_op[idx]));
      else
        idle(1'b1);
      if (last_acc) idx++;
      if (last_ov) outs++;
      else if (outs > 0 && outs < 6) gap++;
    end
    check("bp_all_in", idx, 6);
    check("bp_all_out", outs, 6);
    check("bp_no_gap", gap, 0);
    drain();

    // Test 4: random valid/ready traffic against the reference model
    start_in = n_in;
    start_out = n_out;
    sent = 0;
    guard = 0;
    while (sent < 1000 && guard < 20000) begin
      r_iv  = ($urandom % 4) != 0;
      r_in  = 16'($urandom);
      r_cnt = 4'($urandom);
      r_op  = 2'($urandom);
      step(r_iv, r_in, r_cnt, r_op, ($urandom % 4) != 0, ref_shift(r_in, int'(r_cnt), r_op));
      if (last_acc) sent++;
      guard++;
    end
    check("rand_sent", sent, 1000);
    drain();
    check("rand_in_eq_out", n_out - start_out, n_in - start_in);

    // Test 5: reset mid-flight discards in-flight requests
    for (int i = 0; i < 3; i++) step(1'b1, 16'h5A5A, 4'(i + 1), 2'b01, 1'b1, '0);
    check("mid_accepts", q.size(), 3);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    In = 16'hFFFF;
    Cnt = 4'd1;
    Op = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    q.delete();
    check("mid_out_valid", out_valid, 1'b0);
    check("mid_in_ready", in_ready, 1'b1);
    check("mid_out", Out, 16'h0000);
    lat_chk = 1'b1;
    cyc++;
    step(1'b1, 16'h8001, 4'd1, 2'b00, 1'b1, 16'h0003);
    drain();
    lat_chk = 1'b0;

    // Test 6: simultaneous input and output handshake while full
    idx = 0;
    for (int i = 0; i < 10 && idx < 4; i++) begin
      r_in = 16'($urandom);
      step(1'b1, r_in, 4'(i), 2'b11, 1'b0, ref_shift(r_in, i, 2'b11));
      if (last_acc) idx++;
    end
    check("full_accepts", idx, 4);
    idle(1'b0);
    check("full_in_ready", last_ir, 1'b0);
    step(1'b1, 16'hC3C3, 4'd5, 2'b00, 1'b1, ref_shift(16'hC3C3, 5, 2'b00));
    check("sim_accept", last_acc, 1'b1);
    check("sim_out", last_ov, 1'b1);
    idle(1'b0);
    check("sim_still_full", last_ir, 1'b0);
    check("sim_out_valid", last_ov, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
